// File: rtl/gate_bank_sequencer.sv
// Self-test sequencer for the 7-function gate bank: walks all four operand
// vectors per gate, captures a truth table and flags mismatches against golden.
module gate_bank_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [2:0]  gate_sel,
    input  logic [6:0]  gate_y,
    output logic        a1,
    output logic        b1,
    output logic        busy,
    output logic        done,
    output logic [27:0] truth_tbl,
    output logic [6:0]  err_mask,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_r;
    logic [3:0]  settle_cnt_r;
    logic [2:0]  gate_r;
    logic [1:0]  vec_r;
    logic        mode_r;

    logic [7:0]  gate_y_ext_s;
    logic        sample_bit_s;
    logic        mismatch_s;
    logic [6:0]  err_mask_nxt_s;
    logic [1:0]  vec_nxt_s;

    function automatic logic golden(input logic [2:0] gate, input logic a, input logic b);
        logic g;
        case (gate)
            3'd0:    g = a & b;
            3'd1:    g = ~a;
            3'd2:    g = ~(a & b);
            3'd3:    g = a | b;
            3'd4:    g = ~(a | b);
            3'd5:    g = a ^ b;
            3'd6:    g = ~(a ^ b);
            default: g = 1'b0;
        endcase
        return g;
    endfunction

    // Select the sampled gate output and fold any mismatch into the sticky mask.
    always_comb begin
        gate_y_ext_s   = {1'b0, gate_y};
        sample_bit_s   = gate_y_ext_s[gate_r];
        mismatch_s     = sample_bit_s ^ golden(gate_r, a1, b1);
        vec_nxt_s      = vec_r + 2'd1;
        err_mask_nxt_s = err_mask;
        for (int g = 0; g < 7; g++) begin
            err_mask_nxt_s[g] = (gate_r == 3'(g)) ? (err_mask[g] | mismatch_s) : err_mask[g];
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            settle_cnt_r <= 4'd0;
            gate_r       <= 3'd0;
            vec_r        <= 2'd0;
            mode_r       <= 1'b0;
            a1           <= 1'b0;
            b1           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            truth_tbl    <= 28'd0;
            err_mask     <= 7'd0;
            pass         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    a1   <= 1'b0;
                    b1   <= 1'b0;
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        truth_tbl    <= 28'd0;
                        err_mask     <= 7'd0;
                        pass         <= 1'b0;
                        vec_r        <= 2'd0;
                        settle_cnt_r <= 4'd0;
                        mode_r       <= mode;
                        if ((mode == 1'b0) && (gate_sel == 3'd7)) begin
                            // Illegal selection: report immediately, never touch the bank.
                            gate_r  <= 3'd0;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            gate_r  <= mode ? 3'd0 : gate_sel;
                            busy    <= 1'b1;
                            state_r <= DRIVE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        settle_cnt_r <= 4'd0;
                        state_r      <= SAMPLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 4'd1;
                        state_r      <= DRIVE;
                    end
                end
                SAMPLE: begin
                    truth_tbl[{gate_r, vec_r}] <= sample_bit_s;
                    err_mask                   <= err_mask_nxt_s;
                    if (vec_r != 2'd3) begin
                        vec_r   <= vec_nxt_s;
                        a1      <= vec_nxt_s[1];
                        b1      <= vec_nxt_s[0];
                        state_r <= DRIVE;
                    end else if (mode_r && (gate_r < 3'd6)) begin
                        gate_r  <= gate_r + 3'd1;
                        vec_r   <= 2'd0;
                        a1      <= 1'b0;
                        b1      <= 1'b0;
                        state_r <= DRIVE;
                    end else begin
                        a1      <= 1'b0;
                        b1      <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_mask_nxt_s == 7'd0);
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bank_sequencer.sv
// Directed self-checking bench for gate_bank_sequencer (default settle and a
// second instance with SETTLE_CYCLES = 3).
module tb_gate_bank_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode;
    logic [2:0]  gate_sel;
    logic [6:0]  gate_y, stuck_mask;
    logic        a1, b1, busy, done, pass;
    logic [27:0] truth_tbl;
    logic [6:0]  err_mask;

    logic        start3, mode3;
    logic [2:0]  gate_sel3;
    logic [6:0]  gate_y3;
    logic        a1_3, b1_3, busy3, done3, pass3;
    logic [27:0] truth_tbl3;
    logic [6:0]  err_mask3;

    int n_cmp = 0;
    int n_bad = 0;
    int k, busy_cnt;
    logic [1:0] seq [0:63];

    function automatic logic [6:0] ideal(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), ~a, a & b};
    endfunction

    assign gate_y  = ideal(a1, b1) & ~stuck_mask;
    assign gate_y3 = ideal(a1_3, b1_3);

    gate_bank_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .gate_sel(gate_sel),
        .gate_y(gate_y), .a1(a1), .b1(b1), .busy(busy), .done(done),
        .truth_tbl(truth_tbl), .err_mask(err_mask), .pass(pass)
    );

    gate_bank_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3), .gate_sel(gate_sel3),
        .gate_y(gate_y3), .a1(a1_3), .b1(b1_3), .busy(busy3), .done(done3),
        .truth_tbl(truth_tbl3), .err_mask(err_mask3), .pass(pass3)
    );

    task automatic run_main(input logic m, input logic [2:0] sel);
        @(negedge clk);
        mode = m; gate_sel = sel; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; busy_cnt = 0;
        while (done !== 1'b1 && k < 400) begin
            if (busy === 1'b1) busy_cnt++;
            if (k < 64) seq[k] = {a1, b1};
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a1, b1, busy, done, pass} !== 5'b00000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {a1, b1, busy, done, pass});
        end
        n_cmp++;
        if (truth_tbl !== 28'h0) begin
            n_bad++; $display("FAIL reset_truth: got %h want 0000000", truth_tbl);
        end
        n_cmp++;
        if (err_mask !== 7'h00 || busy3 !== 1'b0 || done3 !== 1'b0) begin
            n_bad++; $display("FAIL reset_err: got err=%h busy3=%b done3=%b want 00/0/0", err_mask, busy3, done3);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sweep_ideal;
        run_main(1'b1, 3'd0);
        n_cmp++;
        if (k !== 56) begin n_bad++; $display("FAIL sweep_latency: got %0d want 56", k); end
        n_cmp++;
        if (busy_cnt !== 56) begin n_bad++; $display("FAIL sweep_busy: got %0d want 56", busy_cnt); end
        n_cmp++;
        if (truth_tbl !== 28'h961E738) begin n_bad++; $display("FAIL sweep_truth: got %h want 961e738", truth_tbl); end
        n_cmp++;
        if (err_mask !== 7'h00 || pass !== 1'b1) begin
            n_bad++; $display("FAIL sweep_pass: got err=%h pass=%b want 00/1", err_mask, pass);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || truth_tbl !== 28'h961E738 || pass !== 1'b1) begin
            n_bad++; $display("FAIL sweep_hold: got done=%b truth=%h pass=%b want 0/961e738/1", done, truth_tbl, pass);
        end
    endtask

    task automatic test_single_xor;
        run_main(1'b0, 3'd5);
        n_cmp++;
        if (k !== 8) begin n_bad++; $display("FAIL xor_latency: got %0d want 8", k); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (seq[i] !== 2'(i / 2)) begin
                n_bad++; $display("FAIL xor_vector[%0d]: got %b want %b", i, seq[i], 2'(i / 2));
            end
        end
        n_cmp++;
        if (truth_tbl !== 28'h0600000 || pass !== 1'b1) begin
            n_bad++; $display("FAIL xor_truth: got %h pass=%b want 0600000/1", truth_tbl, pass);
        end
    endtask

    task automatic test_stuck_xor;
        stuck_mask = 7'b0100000;
        run_main(1'b1, 3'd0);
        stuck_mask = 7'b0000000;
        n_cmp++;
        if (truth_tbl !== 28'h901E738) begin n_bad++; $display("FAIL stuck_truth: got %h want 901e738", truth_tbl); end
        n_cmp++;
        if (err_mask !== 7'b0100000) begin n_bad++; $display("FAIL stuck_err: got %b want 0100000", err_mask); end
        n_cmp++;
        if (pass !== 1'b0) begin n_bad++; $display("FAIL stuck_pass: got %b want 0", pass); end
    endtask

    task automatic test_illegal;
        run_main(1'b0, 3'd7);
        n_cmp++;
        if (k !== 0 || busy_cnt !== 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL illegal_timing: got k=%0d busy_cnt=%0d want 0/0", k, busy_cnt);
        end
        n_cmp++;
        if (truth_tbl !== 28'h0 || err_mask !== 7'h00 || pass !== 1'b0) begin
            n_bad++; $display("FAIL illegal_result: got %h/%h/%b want 0000000/00/0", truth_tbl, err_mask, pass);
        end
    endtask

    task automatic test_back_to_back;
        int hits;
        @(negedge clk);
        mode = 1'b0; gate_sel = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
            if (k == 4) begin start = 1'b1; mode = 1'b1; gate_sel = 3'd7; end
            else if (k == 5) start = 1'b0;
        end
        n_cmp++;
        if (k !== 8 || truth_tbl !== 28'h0000008 || pass !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ignore: got k=%0d truth=%h pass=%b want 8/0000008/1", k, truth_tbl, pass);
        end
        // reset in the middle of a sweep (gate 3)
        @(negedge clk);
        mode = 1'b1; gate_sel = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (26) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({a1, b1, busy, done, pass} !== 5'b00000 || truth_tbl !== 28'h0 || err_mask !== 7'h00) begin
            n_bad++; $display("FAIL midrun_reset: got ctl=%b truth=%h err=%h want 00000/0000000/00",
                              {a1, b1, busy, done, pass}, truth_tbl, err_mask);
        end
        hits = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) hits++;
        end
        n_cmp++;
        if (hits !== 0) begin n_bad++; $display("FAIL reset_no_done: got %0d active cycles want 0", hits); end
        run_main(1'b0, 3'd4);
        n_cmp++;
        if (k !== 8 || truth_tbl !== 28'h0010000 || pass !== 1'b1) begin
            n_bad++; $display("FAIL after_reset_run: got k=%0d truth=%h pass=%b want 8/0010000/1", k, truth_tbl, pass);
        end
    endtask

    task automatic test_settle3;
        @(negedge clk);
        mode3 = 1'b0; gate_sel3 = 3'd1; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        k = 0;
        while (done3 !== 1'b1 && k < 400) begin
            if (k < 64) seq[k] = {a1_3, b1_3};
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k !== 16) begin n_bad++; $display("FAIL s3_latency: got %0d want 16", k); end
        for (int i = 0; i < 16; i += 3) begin
            n_cmp++;
            if (seq[i] !== 2'(i / 4)) begin
                n_bad++; $display("FAIL s3_vector[%0d]: got %b want %b", i, seq[i], 2'(i / 4));
            end
        end
        n_cmp++;
        if (truth_tbl3 !== 28'h0000030 || pass3 !== 1'b1 || err_mask3 !== 7'h00) begin
            n_bad++; $display("FAIL s3_truth: got %h pass=%b err=%h want 0000030/1/00", truth_tbl3, pass3, err_mask3);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; gate_sel = 3'd0; stuck_mask = 7'd0;
        start3 = 1'b0; mode3 = 1'b0; gate_sel3 = 3'd0;
        test_reset();
        test_sweep_ideal();
        test_single_xor();
        test_stuck_xor();
        test_illegal();
        test_back_to_back();
        test_settle3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_bank_sequencer.md
Name: gate_bank_sequencer

Overview:
Self-test and characterisation controller for the team's 7-function logic gate bank (AND, NOT, NAND, OR, NOR, XOR, XNOR). The block drives the bank's two shared operand inputs through all four input combinations, samples the bank's outputs after a programmable settle time, and builds a truth table for either one gate or all seven gates in turn. It checks every sample against an internally generated golden value and reports a per-gate error mask. It sits between a test/host register interface and a gate bank instance; the gate bank's inputs are driven only by this block.

Parameters:
SETTLE_CYCLES, 1, number of cycles operands are held before each sample; legal range 1..15 (4-bit counter).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  run request; accepted only in IDLE.
mode  in  1  0 = single gate (gate_sel), 1 = sweep gates 0..6.
gate_sel  in  3  gate index in single mode: 0 and, 1 not, 2 nand, 3 or, 4 nor, 5 xor, 6 xnor; 7 is illegal.
gate_y  in  7  gate bank outputs, bit g = gate g (same index map as gate_sel).
a1  out  1  operand A to the gate bank (registered).
b1  out  1  operand B to the gate bank (registered).
busy  out  1  high while a run is in progress (DRIVE/SAMPLE).
done  out  1  one-cycle pulse at the end of a run.
truth_tbl  out  28  nibble g = bits [4g+3:4g]; bit v of the nibble = gate g output for {a1,b1} = v.
err_mask  out  7  bit g set if any sample of gate g mismatched golden.
pass  out  1  1 when the last run completed with err_mask == 0 and a legal selection.

Behaviour:
- Reset (any state, mid-run included): state IDLE; a1, b1, busy, done, pass = 0; truth_tbl = 0; err_mask = 0; all counters = 0. Any run in progress is abandoned with no done pulse.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: a1 = b1 = 0. On start = 1:
  - Clear truth_tbl, err_mask and pass.
  - Set gate index = (mode ? 0 : gate_sel) and vector = 0.
  - Load a1 = vector[1], b1 = vector[0] and go to DRIVE.
  - start is ignored in every state other than IDLE. That includes DONE, so a back-to-back start must arrive in IDLE.
- Illegal selection (mode = 0, gate_sel = 7): go straight IDLE -> DONE. No operands are driven; truth_tbl and err_mask stay 0; pass = 0.
- DRIVE: hold a1/b1 for SETTLE_CYCLES cycles (settle counter), then go to SAMPLE.
- SAMPLE (one cycle) captures at the clock edge:
  - truth_tbl[4*gate+vector] <= gate_y[gate].
  - err_mask[gate] is set if gate_y[gate] != golden(gate, a1, b1). It is sticky for the run.
  - Golden values: and a&b, not ~a, nand ~(a&b), or a|b, nor ~(a|b), xor a^b, xnor ~(a^b). Gate NOT ignores b1 but is still stepped through all 4 vectors.
  - Next step:
    - If vector < 3: vector+1, update a1/b1, go to DRIVE.
    - Else if mode = 1 and gate < 6: gate+1, vector = 0, go to DRIVE.
    - Else go to DONE.
- Vector order: 00, 01, 10, 11 as {a1,b1}. Each vector takes SETTLE_CYCLES+1 cycles.
- DONE: lasts one cycle.
  - done = 1, busy = 0, a1 = b1 = 0.
  - pass = (err_mask == 0) and selection legal, using the final err_mask including the last sample.
  - Next state is IDLE.
- busy = 1 in DRIVE and SAMPLE only.
- Latency from the start-accept edge to the done-high cycle:
  - single mode: 4*(SETTLE_CYCLES+1) edges, i.e. 8 for the default.
  - sweep mode: 28*(SETTLE_CYCLES+1) edges, i.e. 56 for the default.
  - illegal selection: 1 edge.
- truth_tbl, err_mask and pass hold after DONE until the next accepted start or reset. In single mode, nibbles of unselected gates read 0.
- gate_y is sampled only in SAMPLE; gate_y changes at any other time are ignored.

Test Plan:
- Reset, then sweep (mode = 1) with an ideal gate bank, SETTLE_CYCLES = 1 -> done after 56 edges; truth_tbl = 28'h961E738, err_mask = 7'h00, pass = 1; busy high for exactly 56 cycles.
- Single mode, gate_sel = 5 (xor), ideal bank -> a1/b1 sequence 00, 01, 10, 11, each held 2 cycles; done after 8 edges; truth_tbl = 28'h0600000; pass = 1.
- Sweep with the bench forcing gate_y[5] stuck at 0 -> xor nibble = 4'h0; err_mask = 7'b0100000; pass = 0; all other nibbles correct.
- Single mode, gate_sel = 7 -> done one edge after start; busy never high; truth_tbl = 0; pass = 0.
- Pulse start again while busy, during vector 2 of a single-mode run -> ignored, run completes normally. Then assert rst mid-sweep (gate 3) -> next cycle IDLE with all outputs 0 and no done pulse; a new start then runs cleanly.
- SETTLE_CYCLES = 3, single mode, gate 1 (not) -> each vector held 4 cycles; done after 16 edges; nibble 1 = 4'h3.
